alu_core: RTL and testbench

Single-stage registered integer ALU sitting between an operand/opcode request channel and a result channel. Each channel uses a valid/ready handshake. The block accepts one operation per cycle. It returns the result, status flags and an illegal-opcode error exactly one cycle after acceptance, and holds that result under output backpressure.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_datapath.sv | 98 +++++++++
 rtl/alu_core.sv | 68 ++++++
 tb/tb_alu_core.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding, default width and status-flag bundle for the ALU.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 16;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_SRA   = 4'd8,
        OP_SLT   = 4'd9,
        OP_SLTU  = 4'd10,
        OP_PASSB = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic err;
    } alu_flags_t;

    // Encodings 12..15 are reserved and report an error beat.
    function automatic logic alu_is_legal(input logic [3:0] op);
        return op <= 4'd11;
    endfunction

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU: computes result and status flags for one opcode/operand set.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]         shamt;
    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic [WIDTH:0]          shl_ext;
    logic [WIDTH:0]          shr_ext;
    logic signed [WIDTH:0]   sra_ext;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        res;
    logic                    carry;
    logic                    ovf;
    logic                    err;
    alu_op_e                 op_e;

    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] d);
        return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign op_e  = alu_op_e'(op);
    assign shamt = b[SH_W-1:0];
    assign a_s   = a;
    assign b_s   = b;

    // One guard bit beyond the operand catches carry/borrow and the shifted-out bit.
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign shl_ext = {1'b0, a} << shamt;
    assign shr_ext = {a, 1'b0} >> shamt;
    assign sra_ext = $signed({a, 1'b0}) >>> shamt;

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        err   = !alu_is_legal(op);
        case (op_e)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = add_ovf(a, b, sum[WIDTH-1:0]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = sub_ovf(a, b, diff[WIDTH-1:0]);
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_NOT:   res = ~a;
            OP_SHL: begin
                res   = shl_ext[WIDTH-1:0];
                carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res   = shr_ext[WIDTH:1];
                carry = shr_ext[0];
            end
            OP_SRA: begin
                res   = sra_ext[WIDTH:1];
                carry = sra_ext[0];
            end
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_PASSB: res = b;
            default:  res = '0;
        endcase
    end

    assign result      = res;
    assign flags.zero  = !err && (res == '0);
    assign flags.neg   = res[WIDTH-1];
    assign flags.carry = carry;
    assign flags.ovf   = ovf;
    assign flags.err   = err;

endmodule

// File: rtl/alu_core.sv
// Registered ALU with valid/ready request and result channels; one op per cycle.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_err
);

    logic [WIDTH-1:0] result_p0;
    alu_flags_t       flags_p0;
    logic [WIDTH-1:0] result_p1;
    alu_flags_t       flags_p1;
    logic             vld_p1;
    logic             accept;

    // Stage 0: combinational compute on the request channel
    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (result_p0),
        .flags  (flags_p0)
    );

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // Stage 1: output register; data holds on drain, only valid drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            flags_p1  <= '0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            result_p1 <= result_p0;
            flags_p1  <= flags_p0;
        end else if (out_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign out_valid  = vld_p1;
    assign out_result = result_p1;
    assign out_zero   = flags_p1.zero;
    assign out_neg    = flags_p1.neg;
    assign out_carry  = flags_p1.carry;
    assign out_ovf    = flags_p1.ovf;
    assign out_err    = flags_p1.err;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core at WIDTH=16: directed vectors, random stream, stalls, reset.
module tb_alu_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_op = 4'd0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_zero, out_neg, out_carry, out_ovf, out_err;
    logic [4:0]   obs_fl;

    // fl order: {zero, neg, carry, ovf, err}
    typedef struct packed {
        logic [W-1:0] res;
        logic [4:0]   fl;
    } exp_t;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [4:0]   fl;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_core #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    assign obs_fl = {out_zero, out_neg, out_carry, out_ovf, out_err};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference model written with plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ua, ub, sa, sb, t, sh;
        logic c, o;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[3:0]);
        c = 1'b0;
        o = 1'b0;
        t = 0;
        case (op)
            4'd0: begin t = ua + ub; c = (t > 65535); o = (sa + sb > 32767) || (sa + sb < -32768); end
            4'd1: begin t = ua - ub; c = (ua < ub);   o = (sa - sb > 32767) || (sa - sb < -32768); end
            4'd2: t = ua & ub;
            4'd3: t = ua | ub;
            4'd4: t = ua ^ ub;
            4'd5: t = ~ua;
            4'd6: begin t = ua << sh; c = (sh != 0) && (((ua >> (16 - sh)) & 1) == 1); end
            4'd7: begin t = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
            4'd8: begin t = sa >>> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
            4'd9:  t = (sa < sb) ? 1 : 0;
            4'd10: t = (ua < ub) ? 1 : 0;
            4'd11: t = ub;
            default: t = 0;
        endcase
        e.res = t[15:0];
        e.fl  = {(t[15:0] == 16'h0), t[15], c, o, 1'b0};
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; in_op = 4'd0; in_a = 16'h0001; in_b = 16'h0001; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0 || obs_fl !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold: got valid=%b res=%h flags=%b, expected valid=0 res=0000 flags=00000",
                     out_valid, out_result, obs_fl);
        end
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected in_ready=1 out_valid=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        vec_t v[$];
        exp_t e;
        v.push_back(vec_t'{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 5'b01010});
        v.push_back(vec_t'{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 5'b10100});
        v.push_back(vec_t'{4'd0,  16'h8000, 16'h8000, 16'h0000, 5'b10110});
        v.push_back(vec_t'{4'd0,  16'h1234, 16'h1111, 16'h2345, 5'b00000});
        v.push_back(vec_t'{4'd1,  16'h0003, 16'h0005, 16'hFFFE, 5'b01100});
        v.push_back(vec_t'{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 5'b00010});
        v.push_back(vec_t'{4'd1,  16'h0005, 16'h0005, 16'h0000, 5'b10000});
        v.push_back(vec_t'{4'd9,  16'hFFFF, 16'h0001, 16'h0001, 5'b00000});
        v.push_back(vec_t'{4'd10, 16'hFFFF, 16'h0001, 16'h0000, 5'b10000});
        v.push_back(vec_t'{4'd9,  16'h0001, 16'hFFFF, 16'h0000, 5'b10000});
        v.push_back(vec_t'{4'd6,  16'h8001, 16'h0001, 16'h0002, 5'b00100});
        v.push_back(vec_t'{4'd6,  16'h1234, 16'h0000, 16'h1234, 5'b00000});
        v.push_back(vec_t'{4'd8,  16'h8000, 16'h0004, 16'hF800, 5'b01000});
        v.push_back(vec_t'{4'd8,  16'h8001, 16'h0001, 16'hC000, 5'b01100});
        v.push_back(vec_t'{4'd7,  16'h8000, 16'h0004, 16'h0800, 5'b00000});
        v.push_back(vec_t'{4'd7,  16'h000F, 16'h0014, 16'h0000, 5'b10100});
        v.push_back(vec_t'{4'd2,  16'hF0F0, 16'hFF00, 16'hF000, 5'b01000});
        v.push_back(vec_t'{4'd3,  16'h0F00, 16'h00F0, 16'h0FF0, 5'b00000});
        v.push_back(vec_t'{4'd4,  16'hFFFF, 16'hFFFF, 16'h0000, 5'b10000});
        v.push_back(vec_t'{4'd5,  16'h0000, 16'h1234, 16'hFFFF, 5'b01000});
        v.push_back(vec_t'{4'd11, 16'h1234, 16'h8000, 16'h8000, 5'b01000});
        out_ready = 1'b1;
        foreach (v[i]) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = v[i].op; in_a = v[i].a; in_b = v[i].b;
            sb_q.push_back(exp_t'{v[i].res, v[i].fl});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_result !== e.res || obs_fl !== e.fl) begin
                errors++;
                $display("FAIL directed[%0d] op=%0d a=%h b=%h: got valid=%b res=%h flags=%b, expected valid=1 res=%h flags=%b",
                         i, v[i].op, v[i].a, v[i].b, out_valid, out_result, obs_fl, e.res, e.fl);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] op;
        logic [W-1:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 11));
            a = W'($urandom);
            b = W'($urandom);
            in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
            sb_q.push_back(model(op, a, b));
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got in_ready=%b, expected 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_result !== e.res || obs_fl !== e.fl) begin
                errors++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got valid=%b res=%h flags=%b, expected valid=1 res=%h flags=%b",
                         i, op, a, b, out_valid, out_result, obs_fl, e.res, e.fl);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 4'd2; in_a = 16'hF0F0; in_b = 16'h0FF0;
        sb_q.push_back(exp_t'{16'h00F0, 5'b00000});
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 16'h00F0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: got valid=%b res=%h in_ready=%b, expected valid=1 res=00f0 in_ready=0",
                     out_valid, out_result, in_ready);
        end
        @(negedge clk);
        in_op = 4'd3; in_a = 16'h1200; in_b = 16'h0034;
        sb_q.push_back(exp_t'{16'h1234, 5'b00000});
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 16'h00F0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: got valid=%b res=%h in_ready=%b, expected valid=1 res=00f0 in_ready=0",
                     out_valid, out_result, in_ready);
        end
        out_ready = 1'b1;
        #1;
        e = sb_q.pop_front();
        checks++;
        if (in_ready !== 1'b1 || out_result !== e.res || obs_fl !== e.fl) begin
            errors++;
            $display("FAIL bp_drain: got in_ready=%b res=%h flags=%b, expected in_ready=1 res=%h flags=%b",
                     in_ready, out_result, obs_fl, e.res, e.fl);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== e.res || obs_fl !== e.fl) begin
            errors++;
            $display("FAIL bp_second: got valid=%b res=%h flags=%b, expected valid=1 res=%h flags=%b",
                     out_valid, out_result, obs_fl, e.res, e.fl);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h1234) begin
            errors++;
            $display("FAIL bp_empty: got valid=%b res=%h, expected valid=0 res=1234 (held)",
                     out_valid, out_result);
        end
    endtask

    task automatic test_illegal_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 4'd13; in_a = 16'hFFFF; in_b = 16'hFFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 16'h0 || out_err !== 1'b1 ||
            out_neg !== 1'b0 || out_carry !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL illegal: got valid=%b res=%h err=%b neg=%b carry=%b ovf=%b, expected valid=1 res=0000 err=1 neg=0 carry=0 ovf=0",
                     out_valid, out_result, out_err, out_neg, out_carry, out_ovf);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        sb_q.delete();
        checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || out_result !== 16'h0) begin
            errors++;
            $display("FAIL reset_async: got valid=%b err=%b res=%h, expected valid=0 err=0 res=0000",
                     out_valid, out_err, out_result);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover: got in_ready=%b out_valid=%b, expected in_ready=1 out_valid=0",
                     in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_illegal_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
